// File: rtl/model_matrix_vector_sequencer.sv
// Matrix-vector sequencer: DATA_OUT[i] = sum_j A[i][j]*B[j] using one shared external multiplier and adder.
// Latency: 5 cycles per element minimum (FETCH 1 + MULTIPLY 2 + ADD 2), plus 1 OUTPUT cycle per row.
// Backpressure: stalls in FETCH until DATA_IN_VALID, and in MULTIPLY/ADD until the unit's READY; no output stall.
//
// Ports:
//   CLK, RST               clock, synchronous active-low reset
//   START/READY/ERROR      operation handshake; READY and ERROR are one-cycle pulses
//   SIZE_A_I_IN/_J_IN/B_IN matrix rows, matrix columns, vector length (latched at START)
//   DATA_IN_*              operand fetch: request + (i,j) index out, valid + A[i][j], B[j] in
//   MULT_*                 multiplier start/ready handshake, operands out, product in
//   ADD_*                  adder start/ready handshake, accumulator and product out, sum in
//   DATA_OUT*              one row result per pulse of DATA_OUT_ENABLE, tagged with its row index
module model_matrix_vector_sequencer #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic                 READY,
  output logic                 ERROR,
  input  logic [DATA_SIZE-1:0] SIZE_A_I_IN,
  input  logic [DATA_SIZE-1:0] SIZE_A_J_IN,
  input  logic [DATA_SIZE-1:0] SIZE_B_IN,
  output logic                 DATA_IN_REQUEST,
  output logic [DATA_SIZE-1:0] INDEX_I_OUT,
  output logic [DATA_SIZE-1:0] INDEX_J_OUT,
  input  logic                 DATA_IN_VALID,
  input  logic [DATA_SIZE-1:0] DATA_A_IN,
  input  logic [DATA_SIZE-1:0] DATA_B_IN,
  output logic                 MULT_START,
  input  logic                 MULT_READY,
  output logic [DATA_SIZE-1:0] MULT_DATA_A_OUT,
  output logic [DATA_SIZE-1:0] MULT_DATA_B_OUT,
  input  logic [DATA_SIZE-1:0] MULT_DATA_IN,
  output logic                 ADD_START,
  output logic                 ADD_OPERATION,
  input  logic                 ADD_READY,
  output logic [DATA_SIZE-1:0] ADD_DATA_A_OUT,
  output logic [DATA_SIZE-1:0] ADD_DATA_B_OUT,
  input  logic [DATA_SIZE-1:0] ADD_DATA_IN,
  output logic                 DATA_OUT_ENABLE,
  output logic [DATA_SIZE-1:0] DATA_OUT_INDEX,
  output logic [DATA_SIZE-1:0] DATA_OUT
);

  // CONTROL_SIZE only configures the arithmetic units next to this block.
  if (CONTROL_SIZE < 1) begin : g_bad_control_size
    $error("CONTROL_SIZE must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    MULTIPLY = 3'd2,
    ADD      = 3'd3,
    OUTPUT   = 3'd4
  } state_t;

  state_t               state_q;
  logic [DATA_SIZE-1:0] size_i_q;
  logic [DATA_SIZE-1:0] size_j_q;
  logic [DATA_SIZE-1:0] i_q;
  logic [DATA_SIZE-1:0] j_q;
  logic [DATA_SIZE-1:0] acc_q;
  logic                 ready_q;
  logic                 error_q;
  logic                 req_q;
  logic                 mult_start_q;
  logic                 add_start_q;
  logic                 out_en_q;
  logic [DATA_SIZE-1:0] mult_a_q;
  logic [DATA_SIZE-1:0] mult_b_q;
  logic [DATA_SIZE-1:0] add_a_q;
  logic [DATA_SIZE-1:0] add_b_q;
  logic [DATA_SIZE-1:0] out_idx_q;
  logic [DATA_SIZE-1:0] out_dat_q;

  logic last_j_d;
  logic last_i_d;

  // End tests use the latched sizes, which are never zero once a run is
  // underway, so the index counters cannot wrap.
  assign last_j_d = (j_q == size_j_q - DATA_SIZE'(1));
  assign last_i_d = (i_q == size_i_q - DATA_SIZE'(1));

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q      <= IDLE;
      size_i_q     <= '0;
      size_j_q     <= '0;
      i_q          <= '0;
      j_q          <= '0;
      acc_q        <= '0;
      ready_q      <= 1'b0;
      error_q      <= 1'b0;
      req_q        <= 1'b0;
      mult_start_q <= 1'b0;
      add_start_q  <= 1'b0;
      out_en_q     <= 1'b0;
      mult_a_q     <= '0;
      mult_b_q     <= '0;
      add_a_q      <= '0;
      add_b_q      <= '0;
      out_idx_q    <= '0;
      out_dat_q    <= '0;
    end else begin
      // All strobes are single-cycle unless re-armed below.
      ready_q      <= 1'b0;
      error_q      <= 1'b0;
      mult_start_q <= 1'b0;
      add_start_q  <= 1'b0;
      out_en_q     <= 1'b0;

      case (state_q)
        IDLE: begin
          if (START) begin
            if (SIZE_A_J_IN != SIZE_B_IN) begin
              error_q <= 1'b1;
            end else if ((SIZE_A_I_IN == '0) || (SIZE_A_J_IN == '0)) begin
              ready_q <= 1'b1;
            end else begin
              size_i_q <= SIZE_A_I_IN;
              size_j_q <= SIZE_A_J_IN;
              i_q      <= '0;
              j_q      <= '0;
              acc_q    <= '0;
              req_q    <= 1'b1;
              state_q  <= FETCH;
            end
          end
        end

        FETCH: begin
          if (DATA_IN_VALID) begin
            mult_a_q     <= DATA_A_IN;
            mult_b_q     <= DATA_B_IN;
            req_q        <= 1'b0;
            mult_start_q <= 1'b1;
            state_q      <= MULTIPLY;
          end
        end

        // mult_start_q is high only on the first MULTIPLY cycle; a READY
        // coincident with the start pulse belongs to no request of ours.
        MULTIPLY: begin
          if (!mult_start_q && MULT_READY) begin
            add_b_q     <= MULT_DATA_IN;
            add_a_q     <= acc_q;
            add_start_q <= 1'b1;
            state_q     <= ADD;
          end
        end

        ADD: begin
          if (!add_start_q && ADD_READY) begin
            acc_q <= ADD_DATA_IN;
            if (last_j_d) begin
              out_dat_q <= ADD_DATA_IN;
              out_idx_q <= i_q;
              out_en_q  <= 1'b1;
              // READY rides along with the final row's output cycle.
              ready_q   <= last_i_d;
              state_q   <= OUTPUT;
            end else begin
              j_q     <= j_q + DATA_SIZE'(1);
              req_q   <= 1'b1;
              state_q <= FETCH;
            end
          end
        end

        OUTPUT: begin
          if (last_i_d) begin
            state_q <= IDLE;
          end else begin
            i_q     <= i_q + DATA_SIZE'(1);
            j_q     <= '0;
            acc_q   <= '0;
            req_q   <= 1'b1;
            state_q <= FETCH;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign READY           = ready_q;
  assign ERROR           = error_q;
  assign DATA_IN_REQUEST = req_q;
  assign INDEX_I_OUT     = i_q;
  assign INDEX_J_OUT     = j_q;
  assign MULT_START      = mult_start_q;
  assign MULT_DATA_A_OUT = mult_a_q;
  assign MULT_DATA_B_OUT = mult_b_q;
  assign ADD_START       = add_start_q;
  assign ADD_OPERATION   = 1'b0;
  assign ADD_DATA_A_OUT  = add_a_q;
  assign ADD_DATA_B_OUT  = add_b_q;
  assign DATA_OUT_ENABLE = out_en_q;
  assign DATA_OUT_INDEX  = out_idx_q;
  assign DATA_OUT        = out_dat_q;

endmodule
